// File: rtl/pic_cmd_sequencer.sv
// pic_cmd_sequencer
//   Bus-side command sequencer for the PIC. Samples the CPU write/read strobes
//   on the system clock, tracks the ICW1 -> ICW2 -> (ICW3) -> (ICW4)
//   initialization sequence and classifies OCW1/2/3 writes afterwards. Each
//   committed write becomes a one-cycle command-word event for the control
//   logic.
//
// Ports:
//   clk        in   system clock, all state updates on the rising edge
//   rst_n      in   synchronous active-low reset
//   cs_n       in   chip select, active low
//   wr_n       in   write strobe, active low; a command commits on its rise
//   rd_n       in   read strobe, active low
//   a0         in   address bit A0
//   din[7:0]   in   CPU data bus
//   flag_out   out  command-word index 0..6 (ICW1..ICW4, OCW1..OCW3), else FLAG_IDLE
//   cw_data    out  data byte belonging to flag_out (holds after the event)
//   read_sel   out  read source: 3'b011 IMR, 3'b001 IRR, 3'b101 ISR, 3'b000 none
//   init_done  out  high once the ICW sequence is complete
//   seq_err    out  one-cycle pulse on an illegal write
module pic_cmd_sequencer #(
   parameter logic [2:0] FLAG_IDLE  = 3'b111,
   parameter logic [2:0] RD_DEFAULT = 3'b001
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cs_n,
   input  logic       wr_n,
   input  logic       rd_n,
   input  logic       a0,
   input  logic [7:0] din,
   output logic [2:0] flag_out,
   output logic [7:0] cw_data,
   output logic [2:0] read_sel,
   output logic       init_done,
   output logic       seq_err
);

   typedef enum logic [2:0] {
      ST_UNINIT = 3'd0,
      ST_W_ICW2 = 3'd1,
      ST_W_ICW3 = 3'd2,
      ST_W_ICW4 = 3'd3,
      ST_READY  = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic        sngl_q, sngl_d;
   logic        ic4_q, ic4_d;
   logic [2:0]  rd_src_q, rd_src_d;
   logic [2:0]  flag_q, flag_d;
   logic [7:0]  cw_data_q, cw_data_d;
   logic        init_done_q, init_done_d;
   logic        seq_err_q, seq_err_d;

   // Strobe sampling registers (previous wr_n/cs_n, address/data of last low-strobe cycle)
   logic        wr_dly_q;
   logic        cs_dly_q;
   logic        a0_dly_q;
   logic [7:0]  din_dly_q;

   logic        wr_event_s;
   logic        is_icw1_s;

   // A write commits on the first high cycle after a selected low strobe.
   assign wr_event_s = wr_n & ~wr_dly_q & ~cs_dly_q;
   // ICW1 is recognised in every state and restarts the sequence.
   assign is_icw1_s  = ~a0_dly_q & din_dly_q[4];

   // Strobe and bus sampling
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_dly_q  <= 1'b1;
         cs_dly_q  <= 1'b1;
         a0_dly_q  <= 1'b0;
         din_dly_q <= 8'h00;
      end else begin
         wr_dly_q <= wr_n;
         cs_dly_q <= cs_n;
         if (!wr_n && !cs_n) begin
            a0_dly_q  <= a0;
            din_dly_q <= din;
         end else begin
            a0_dly_q  <= a0_dly_q;
            din_dly_q <= din_dly_q;
         end
      end
   end

   // Sequencer state and registered outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_UNINIT;
         sngl_q      <= 1'b1;
         ic4_q       <= 1'b0;
         rd_src_q    <= RD_DEFAULT;
         flag_q      <= FLAG_IDLE;
         cw_data_q   <= 8'h00;
         init_done_q <= 1'b0;
         seq_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         sngl_q      <= sngl_d;
         ic4_q       <= ic4_d;
         rd_src_q    <= rd_src_d;
         flag_q      <= flag_d;
         cw_data_q   <= cw_data_d;
         init_done_q <= init_done_d;
         seq_err_q   <= seq_err_d;
      end
   end

   // Next-state decode of a committed write
   always_comb begin
      state_d   = state_q;
      sngl_d    = sngl_q;
      ic4_d     = ic4_q;
      rd_src_d  = rd_src_q;
      flag_d    = FLAG_IDLE;
      cw_data_d = cw_data_q;
      seq_err_d = 1'b0;

      if (wr_event_s) begin
         if (is_icw1_s) begin
            flag_d    = 3'd0;
            cw_data_d = din_dly_q;
            sngl_d    = din_dly_q[1];
            ic4_d     = din_dly_q[0];
            rd_src_d  = RD_DEFAULT;
            state_d   = ST_W_ICW2;
         end else begin
            case (state_q)
               ST_UNINIT: begin
                  seq_err_d = 1'b1;
               end
               ST_W_ICW2: begin
                  if (a0_dly_q) begin
                     flag_d    = 3'd1;
                     cw_data_d = din_dly_q;
                     if (!sngl_q) begin
                        state_d = ST_W_ICW3;
                     end else if (ic4_q) begin
                        state_d = ST_W_ICW4;
                     end else begin
                        state_d = ST_READY;
                     end
                  end else begin
                     seq_err_d = 1'b1;
                  end
               end
               ST_W_ICW3: begin
                  if (a0_dly_q) begin
                     flag_d    = 3'd2;
                     cw_data_d = din_dly_q;
                     state_d   = ic4_q ? ST_W_ICW4 : ST_READY;
                  end else begin
                     seq_err_d = 1'b1;
                  end
               end
               ST_W_ICW4: begin
                  if (a0_dly_q) begin
                     flag_d    = 3'd3;
                     cw_data_d = din_dly_q;
                     state_d   = ST_READY;
                  end else begin
                     seq_err_d = 1'b1;
                  end
               end
               ST_READY: begin
                  cw_data_d = din_dly_q;
                  if (a0_dly_q) begin
                     flag_d = 3'd4;
                  end else if (!din_dly_q[3]) begin
                     flag_d = 3'd5;
                  end else begin
                     flag_d = 3'd6;
                     // OCW3 read-register command only acts when RR is set.
                     if (din_dly_q[1]) begin
                        rd_src_d = din_dly_q[0] ? 3'b101 : 3'b001;
                     end else begin
                        rd_src_d = rd_src_q;
                     end
                  end
               end
               default: begin
                  state_d = ST_UNINIT;
               end
            endcase
         end
      end else begin
         state_d = state_q;
      end

      init_done_d = (state_d == ST_READY);
   end

   // Read source select; a read colliding with a write event is suppressed.
   always_comb begin
      read_sel = 3'b000;
      if (!cs_n && !rd_n && init_done_q && !wr_event_s) begin
         read_sel = a0 ? 3'b011 : rd_src_q;
      end else begin
         read_sel = 3'b000;
      end
   end

   assign flag_out  = flag_q;
   assign cw_data   = cw_data_q;
   assign init_done = init_done_q;
   assign seq_err   = seq_err_q;

endmodule

// File: doc/pic_cmd_sequencer.md
Name: pic_cmd_sequencer

Overview:
Bus-side command sequencer for the PIC. It samples the CPU write/read strobes on the system clock and tracks the ICW1→ICW2→(ICW3)→(ICW4) initialization sequence. After initialization it classifies OCW1/2/3 writes. Its outputs drive the control logic's command-word flag, data and read-select inputs as one-cycle, clean events, replacing the level-sensitive flag decode.

Parameters:
FLAG_IDLE, 3'b111, value of flag_out when no command word is being delivered
RD_DEFAULT, 3'b001, read_sel value after ICW1 (IRR read)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising clk
cs_n  input  1  chip select, active low
wr_n  input  1  write strobe, active low; a command commits on its rising edge
rd_n  input  1  read strobe, active low
a0  input  1  address bit A0
din  input  8  CPU data bus in
flag_out  output  3  command-word index 0..6 (ICW1..ICW4, OCW1..OCW3), else FLAG_IDLE
cw_data  output  8  data byte belonging to flag_out
read_sel  output  3  read source: 3'b011 IMR, 3'b001 IRR, 3'b101 ISR, 3'b000 no read
init_done  output  1  high once the ICW sequence is complete
seq_err  output  1  one-cycle pulse on an illegal write

Behaviour:
- Reset (rst_n=0 at clk edge):
  - state=UNINIT, flag_out=FLAG_IDLE, cw_data=0, read_sel=0, init_done=0, seq_err=0
  - internal sngl=1, ic4=0, rd_src=RD_DEFAULT, wr_d=1, cs_d=1, a0_d=0, din_d=0
- Sampling, every cycle:
  - wr_d<=wr_n, cs_d<=cs_n.
  - While wr_n=0 and cs_n=0: a0_d<=a0, din_d<=din.
- Write event: a cycle with wr_n=1, wr_d=0 and cs_d=0. It is decoded from a0_d/din_d, so data is that of the last low-strobe cycle.
- Output latency: flag_out/cw_data are valid on the edge after the write event, for exactly one cycle. Then flag_out returns to FLAG_IDLE. cw_data holds its last value.
- Decode precedence: a0_d=0 with din_d[4]=1 is ICW1 in any state, including mid-init. It restarts the sequence.
- On ICW1:
  - flag=0; sngl<=din_d[1], ic4<=din_d[0]
  - rd_src<=RD_DEFAULT, init_done<=0, state<=W_ICW2
- States and transitions:
  - UNINIT: any non-ICW1 write → seq_err pulse, no flag.
  - W_ICW2: a0_d=1 → flag=1. Next state W_ICW3 if sngl=0, else W_ICW4 if ic4=1, else READY.
  - W_ICW3: a0_d=1 → flag=2. Next state W_ICW4 if ic4=1, else READY.
  - W_ICW4: a0_d=1 → flag=3, state READY.
  - In W_ICW2/W_ICW3/W_ICW4, an a0_d=0 non-ICW1 write → seq_err, state unchanged.
  - READY:
    - a0_d=1 → flag=4 (OCW1)
    - a0_d=0, din_d[4:3]=00 → flag=5 (OCW2)
    - a0_d=0, din_d[4:3]=01 → flag=6 (OCW3)
    - If din_d[1]=1 (RR): rd_src<=din_d[0] ? 3'b101 : 3'b001. RR=0 leaves rd_src unchanged.
- init_done: set on the edge entering READY, cleared on ICW1 or reset.
- read_sel is combinational from registered state, valid only when cs_n=0, rd_n=0 and init_done=1:
  - a0=1 → 3'b011
  - a0=0 → rd_src
  - otherwise 3'b000
  - A read before init_done returns 3'b000.
- Simultaneous rd_n=0 and write event: the write is processed and read_sel is forced to 0 that cycle.
- Write with cs_d=1: ignored, with no seq_err.
- Back-to-back writes need at least one wr_n-high cycle between them. Each rising strobe yields exactly one event.
- Reset mid-sequence: returns to UNINIT. Any pending flag is dropped.

Test Plan:
- Reset → flag_out=3'b111, init_done=0, read_sel=0. Write a0=0, din=8'h13, then a0=1, din=8'h20, then a0=1, din=8'h01 → flags 0,1,3 (ICW3 skipped); init_done=1 one edge after ICW4.
- Cascade init, ICW1=8'h11, ICW2=8'h08, ICW3=8'h04, ICW4=8'h1D → flags 0,1,2,3, each one cycle wide, with cw_data matching.
- READY, write a0=1/8'hFE, a0=0/8'h20, a0=0/8'h0B → flags 4,5,6. A read with a0=0 then gives read_sel=3'b101; a read with a0=1 gives 3'b011.
- In W_ICW2, write a0=0/8'h20 → seq_err pulses once, no flag, and the next a0=1 write yields flag=1.
- Mid-W_ICW3, write a0=0/8'h12 → flag=0, sngl=1, the next a0=1 write gives flag=1, and the state goes straight to READY.
- Drive rst_n=0 one cycle during W_ICW4 → UNINIT, init_done=0, and a following a0=1 write raises seq_err.
